// File: rtl/lstm_elem_seq_if.sv
// Purpose : handshake/control bundle between the LSTM element sequencer and its
//           host (gate producer, datapath, ct/ht state buffer).
// Latency : n/a (wiring only).
// Backpressure: gate_valid/gate_ready on the input side, out_valid/out_ready on
//           the write-back side.
// Ports (signals):
//   start, abort, num_elem        host -> sequencer run control
//   gate_valid / gate_ready       gate pre-activation handshake
//   comb_ctrl, regA_we, ctht_we   datapath stage select and capture strobes
//   out_valid / out_ready         ct/ht write-back handshake
//   elem_idx, busy, done          status
interface lstm_elem_seq_if #(
  parameter int ELEM_W = 8
);
  logic              start;
  logic              abort;
  logic [ELEM_W-1:0] num_elem;
  logic              gate_valid;
  logic              gate_ready;
  logic [4:0]        comb_ctrl;
  logic              regA_we;
  logic              ctht_we;
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] elem_idx;
  logic              busy;
  logic              done;

  // Host / environment side.
  modport master (
    output start, abort, num_elem, gate_valid, out_ready,
    input  gate_ready, comb_ctrl, regA_we, ctht_we, out_valid,
           elem_idx, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, abort, num_elem, gate_valid, out_ready,
    output gate_ready, comb_ctrl, regA_we, ctht_we, out_valid,
           elem_idx, busy, done
  );
endinterface

// File: rtl/lstm_elem_seq.sv
// Purpose : per-element sequencer for the LSTM cell-update datapath; walks each
//           hidden element through LOAD -> BQS -> BQT -> MAQ -> TMQ -> WRITE.
// Latency : N*(2+4*COMB_CYC)+1 cycles from start acceptance to done, no stalls.
// Backpressure: stalls in LOAD while gate_valid is low and in WRITE while
//           out_ready is low; all outputs hold steady during a stall.
// Ports:
//   clk     rising-edge clock
//   rstn    asynchronous active-low reset
//   bus     lstm_elem_seq_if.slave: start/abort/num_elem, gate and write-back
//           handshakes, comb_ctrl + capture strobes, elem_idx/busy/done status
// Parameters:
//   ELEM_W    width of element count / index
//   COMB_CYC  cycles each compute stage holds comb_ctrl, legal 1..15
module lstm_elem_seq #(
  parameter int ELEM_W   = 8,
  parameter int COMB_CYC = 1
) (
  input  logic            clk,
  input  logic            rstn,
  lstm_elem_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BQS,
    S_BQT,
    S_MAQ,
    S_TMQ,
    S_WRITE,
    S_DONE
  } state_t;

  // comb_ctrl encodings seen by the datapath mux.
  localparam logic [4:0] CC_IDLE = 5'd0;
  localparam logic [4:0] CC_BQS  = 5'd1;
  localparam logic [4:0] CC_BQT  = 5'd2;
  localparam logic [4:0] CC_MAQ  = 5'd3;
  localparam logic [4:0] CC_TMQ  = 5'd4;

  // Hold counter is 4 bits wide; COMB_CYC is therefore limited to 15.
  localparam logic [3:0] CNT_LAST = 4'(COMB_CYC - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ELEM_W-1:0] elem_idx_q, elem_idx_d;
  logic [ELEM_W-1:0] num_lat_q, num_lat_d;

  logic [4:0]        comb_ctrl;
  logic              regA_we;
  logic              ctht_we;
  logic              gate_ready;
  logic              out_valid;
  logic              done;
  logic              cnt_last;
  logic              idx_last;

  assign cnt_last = (cnt_q == CNT_LAST);
  // num_lat_q is never zero once WRITE is reachable, so the decrement cannot wrap.
  assign idx_last = (elem_idx_q == (num_lat_q - ELEM_W'(1)));

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      elem_idx_q <= '0;
      num_lat_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      elem_idx_q <= elem_idx_d;
      num_lat_q  <= num_lat_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    elem_idx_d = elem_idx_q;
    num_lat_d  = num_lat_q;
    comb_ctrl  = CC_IDLE;
    regA_we    = 1'b0;
    ctht_we    = 1'b0;
    gate_ready = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          num_lat_d  = bus.num_elem;
          elem_idx_d = '0;
          cnt_d      = 4'd0;
          state_d    = (bus.num_elem == '0) ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        gate_ready = bus.gate_valid;
        if (bus.gate_valid) begin
          state_d = S_BQS;
          cnt_d   = 4'd0;
        end
      end

      // Each compute stage holds comb_ctrl for COMB_CYC cycles so the
      // combinational datapath gets a multicycle budget; the capture strobe
      // fires only in the final held cycle when the result has settled.
      S_BQS: begin
        comb_ctrl = CC_BQS;
        regA_we   = cnt_last;
        if (cnt_last) begin
          state_d = S_BQT;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end

      S_BQT: begin
        comb_ctrl = CC_BQT;
        if (cnt_last) begin
          state_d = S_MAQ;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end

      S_MAQ: begin
        comb_ctrl = CC_MAQ;
        regA_we   = cnt_last;
        if (cnt_last) begin
          state_d = S_TMQ;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end

      S_TMQ: begin
        comb_ctrl = CC_TMQ;
        ctht_we   = cnt_last;
        if (cnt_last) begin
          state_d = S_WRITE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end

      S_WRITE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          cnt_d = 4'd0;
          if (idx_last) begin
            state_d = S_DONE;
          end else begin
            elem_idx_d = elem_idx_q + ELEM_W'(1);
            state_d    = S_LOAD;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Abort overrides everything: return to IDLE, keep the index/count as
    // they were, and squash any capture strobe or done pulse this cycle so a
    // partially computed element never lands in the state buffer.
    if (bus.abort) begin
      state_d    = S_IDLE;
      cnt_d      = 4'd0;
      elem_idx_d = elem_idx_q;
      num_lat_d  = num_lat_q;
      regA_we    = 1'b0;
      ctht_we    = 1'b0;
      done       = 1'b0;
    end
  end

  assign bus.comb_ctrl  = comb_ctrl;
  assign bus.regA_we    = regA_we;
  assign bus.ctht_we    = ctht_we;
  assign bus.gate_ready = gate_ready;
  assign bus.out_valid  = out_valid;
  assign bus.done       = done;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.elem_idx   = elem_idx_q;

endmodule

// File: tb/tb_lstm_elem_seq.sv
// Purpose : self-checking bench for lstm_elem_seq (COMB_CYC=1 and COMB_CYC=3).
// Latency : expected per-cycle traces derived from the stage schedule.
// Backpressure: gate_valid / out_ready stalls driven from the stimulus queue.
module tb_lstm_elem_seq;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  lstm_elem_seq_if #(.ELEM_W(8)) if1 ();
  lstm_elem_seq_if #(.ELEM_W(8)) if3 ();

  lstm_elem_seq #(.ELEM_W(8), .COMB_CYC(1)) dut1 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (if1.slave)
  );

  lstm_elem_seq #(.ELEM_W(8), .COMB_CYC(3)) dut3 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (if3.slave)
  );

  // Observed/expected output word: {comb_ctrl, regA_we, ctht_we, out_valid,
  // gate_ready, busy, done, elem_idx}.
  typedef struct packed {
    logic        gv;
    logic        orr;
    logic [18:0] exp;
  } step_t;

  typedef struct {
    int    sel;
    int    n;
    int    gstall;
    int    rstall;
    int    done_cyc;
    string name;
  } vec_t;

  step_t sb_q[$];
  vec_t  vecs[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic logic [18:0] pk(int cc, bit ra, bit ct, bit ov, bit gr,
                                     bit bz, bit dn, int idx);
    logic [4:0] c5;
    logic [7:0] i8;
    c5 = 5'(cc);
    i8 = 8'(idx);
    return {c5, ra, ct, ov, gr, bz, dn, i8};
  endfunction

  task automatic drive(int sel, logic st, logic ab, logic [7:0] num, logic gv, logic orr);
    if (sel == 1) begin
      if1.start = st; if1.abort = ab; if1.num_elem = num;
      if1.gate_valid = gv; if1.out_ready = orr;
    end else begin
      if3.start = st; if3.abort = ab; if3.num_elem = num;
      if3.gate_valid = gv; if3.out_ready = orr;
    end
  endtask

  task automatic sample(int sel, output logic [18:0] o);
    if (sel == 1)
      o = {if1.comb_ctrl, if1.regA_we, if1.ctht_we, if1.out_valid,
           if1.gate_ready, if1.busy, if1.done, if1.elem_idx};
    else
      o = {if3.comb_ctrl, if3.regA_we, if3.ctht_we, if3.out_valid,
           if3.gate_ready, if3.busy, if3.done, if3.elem_idx};
  endtask

  task automatic check(string name, int k, logic [18:0] act, logic [18:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got cc=%0d ra=%b ct=%b ov=%b gr=%b busy=%b done=%b idx=%0d required cc=%0d ra=%b ct=%b ov=%b gr=%b busy=%b done=%b idx=%0d",
               name, k, act[18:14], act[13], act[12], act[11], act[10], act[9], act[8], act[7:0],
               exp[18:14], exp[13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // Expected trace from the stage schedule: LOAD (+stall), four compute
  // stages of C cycles with strobes on the last one, WRITE (+stall), then
  // DONE and one trailing IDLE cycle. Stalls apply to element 0 only.
  task automatic build(int c, int n, int gs, int rs);
    step_t s;
    for (int e = 0; e < n; e++) begin
      for (int i = 0; i < ((e == 0) ? gs : 0); i++) begin
        s.gv = 1'b0; s.orr = 1'b1; s.exp = pk(0, 0, 0, 0, 0, 1, 0, e);
        sb_q.push_back(s);
      end
      s.gv = 1'b1; s.orr = 1'b1; s.exp = pk(0, 0, 0, 0, 1, 1, 0, e);
      sb_q.push_back(s);
      for (int st = 1; st <= 4; st++) begin
        for (int i = 0; i < c; i++) begin
          s.gv  = 1'b1; s.orr = 1'b1;
          s.exp = pk(st, (i == c-1) && (st == 1 || st == 3), (i == c-1) && (st == 4),
                     0, 0, 1, 0, e);
          sb_q.push_back(s);
        end
      end
      for (int i = 0; i < ((e == 0) ? rs : 0); i++) begin
        s.gv = 1'b1; s.orr = 1'b0; s.exp = pk(0, 0, 0, 1, 0, 1, 0, e);
        sb_q.push_back(s);
      end
      s.gv = 1'b1; s.orr = 1'b1; s.exp = pk(0, 0, 0, 1, 0, 1, 0, e);
      sb_q.push_back(s);
    end
    s.gv = 1'b1; s.orr = 1'b1; s.exp = pk(0, 0, 0, 0, 0, 1, 1, (n == 0) ? 0 : n-1);
    sb_q.push_back(s);
    s.gv = 1'b1; s.orr = 1'b1; s.exp = pk(0, 0, 0, 0, 0, 0, 0, (n == 0) ? 0 : n-1);
    sb_q.push_back(s);
  endtask

  // Called just after an active edge (+1); returns at the same phase.
  task automatic run(vec_t v);
    step_t       s;
    logic [18:0] o;
    int          k;
    int          done_at;
    build((v.sel == 1) ? 1 : 3, v.n, v.gstall, v.rstall);
    drive(v.sel, 1'b1, 1'b0, 8'(v.n), 1'b1, 1'b1);
    @(posedge clk); #1;
    k = 1;
    done_at = -1;
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      drive(v.sel, 1'b0, 1'b0, 8'(v.n), s.gv, s.orr);
      #1;
      sample(v.sel, o);
      check(v.name, k, o, s.exp);
      if (o[8] === 1'b1 && done_at < 0) done_at = k;
      @(posedge clk); #1;
      k++;
    end
    n_vec++;
    if (done_at != v.done_cyc) begin
      n_err++;
      $display("FAIL %s_done_cycle got %0d required %0d", v.name, done_at, v.done_cyc);
    end
  endtask

  initial begin
    logic [18:0] o;
    vec_t        v;

    drive(1, 0, 0, 8'd0, 1'b0, 1'b0);
    drive(3, 0, 0, 8'd0, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    sample(1, o); check("reset_c1", 0, o, pk(0, 0, 0, 0, 0, 0, 0, 0));
    sample(3, o); check("reset_c3", 0, o, pk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    sample(1, o); check("post_reset", 0, o, pk(0, 0, 0, 0, 0, 0, 0, 0));

    // T1: reset asserted mid-TMQ clears outputs immediately.
    drive(1, 1'b1, 1'b0, 8'd1, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    sample(1, o); check("t1_in_tmq", 5, o, pk(4, 0, 1, 0, 0, 1, 0, 0));
    rstn = 1'b0;
    #1;
    sample(1, o); check("t1_rst_async", 5, o, pk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    sample(1, o); check("t1_after_rel", 0, o, pk(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    sample(1, o); check("t1_stays_idle", 0, o, pk(0, 0, 0, 0, 0, 0, 0, 0));

    vecs.push_back('{1, 3,   0, 0, 19,   "t2_n3"});
    vecs.push_back('{3, 1,   0, 0, 15,   "t3_c3"});
    vecs.push_back('{1, 2,   5, 4, 22,   "t4_stall"});
    vecs.push_back('{1, 0,   0, 0, 1,    "t5_n0"});
    vecs.push_back('{3, 2,   0, 0, 29,   "c3_n2"});
    vecs.push_back('{3, 1,   2, 3, 20,   "c3_stall"});
    vecs.push_back('{1, 255, 0, 0, 1531, "n_max"});
    foreach (vecs[i]) run(vecs[i]);

    // T6: abort during MAQ of element 1 (cycle 10 of a 4-element run).
    drive(1, 1'b1, 1'b0, 8'd4, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 8'd4, 1'b1, 1'b1);
    repeat (9) begin @(posedge clk); #1; end
    drive(1, 1'b0, 1'b1, 8'd4, 1'b1, 1'b1);
    #1;
    sample(1, o); check("t6_abort_maq", 10, o, pk(3, 0, 0, 0, 0, 1, 0, 1));
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 8'd4, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      sample(1, o); check("t6_idle_after", 11 + i, o, pk(0, 0, 0, 0, 0, 0, 0, 1));
      @(posedge clk); #1;
    end
    v = '{1, 1, 0, 0, 7, "t6_restart"};
    run(v);

    // start and abort together in IDLE: abort wins.
    drive(1, 1'b1, 1'b1, 8'd3, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b1);
    #1;
    sample(1, o); check("start_abort_idle", 1, o, pk(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    sample(1, o); check("start_abort_idle2", 2, o, pk(0, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
